cyq_coin_feeder: RTL and testbench
==================================

CYQ_COIN_FEEDER -- requirements
Module: cyq_coin_feeder

Interface
REQ-001 Parameter GAP, default 1: number of idle cycles (D_in=00) inserted after every coin pulse; legal range 1..7.
REQ-002 Parameter TIMEOUT, default 8: cycles to wait for D_out after the last gap; legal range 1..15.
REQ-003 Clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Rst  input  1  synchronous, active-low reset, sampled on the rising edge of Clk.
REQ-005 Start  input  1  request pulse; sampled only in IDLE.
REQ-006 Amount  input  4  payment in half-units (1 = 0.5 yuan, max 15 = 7.5 yuan); captured with Start.
REQ-007 D_out  input  1  dispense indication from the vending machine.
REQ-008 D_C  input  1  change indication from the vending machine.
REQ-009 D_in  output  2  registered coin code to the vending machine: 00 none, 01 = 0.5, 10 = 1.0; 11 is never driven.
REQ-010 Busy  output  1  high in every state except IDLE.
REQ-011 Done  output  1  one-cycle pulse when D_out is observed.
REQ-012 Err  output  1  one-cycle pulse on a zero-amount Start or a timeout.
REQ-013 Change_seen  output  1  sticky flag: D_C observed during the current transaction.

Function
REQ-014 The FSM SHALL have states IDLE, COIN, GAP, WAIT and DONE, held in a registered state vector.
REQ-015 In IDLE, Start=1 with Amount!=0 SHALL load Remain<=Amount, clear Change_seen and enter COIN on the next edge.
REQ-016 In IDLE, Start=1 with Amount=0 SHALL pulse Err for one cycle and remain in IDLE.
REQ-017 Start SHALL be ignored in every state other than IDLE.
REQ-018 COIN SHALL last exactly one cycle; D_in=10 and Remain-=2 if Remain>=2, otherwise D_in=01 and Remain-=1 (greedy, largest coin first).
REQ-019 Timing: D_in SHALL show the coin in the first cycle after the Start edge; latency Start->first coin = 1 cycle.
REQ-020 GAP SHALL hold D_in=00 for exactly GAP cycles using a 3-bit counter, then go to COIN if Remain!=0, else to WAIT.
REQ-021 WAIT SHALL hold D_in=00 and count up to TIMEOUT cycles with a 4-bit counter; on expiry it SHALL pulse Err and go to IDLE.
REQ-022 D_out=1 sampled in COIN, GAP or WAIT SHALL move the FSM to DONE on the next edge, discarding any remaining coins; D_in=00 from that edge on.
REQ-023 DONE SHALL assert Done for exactly one cycle and then return to IDLE.
REQ-024 D_C=1 sampled in COIN, GAP, WAIT or DONE SHALL set Change_seen; it holds until the next accepted Start or reset.
REQ-025 If D_out and D_C are high in the same cycle, both REQ-022 and REQ-024 SHALL apply.
REQ-026 The number of COIN cycles SHALL equal ceil(Amount/2) unless aborted by D_out; the sum of coin values SHALL equal Amount.

Reset
REQ-027 With Rst=0 at a rising edge, the block SHALL enter IDLE with D_in=00, Busy=0, Done=0, Err=0, Change_seen=0, and Remain and both counters cleared.
REQ-028 Reset asserted mid-transaction SHALL abort immediately, with no further coins after that edge.
REQ-029 Outputs SHALL be undefined-free: every output register is reset.

Verification
REQ-030 GAP=1, Amount=5, Start pulse, D_out held 0: D_in = 10,00,10,00,01,00, then WAIT with 00 for 8 cycles, Err pulse, IDLE.
REQ-031 Amount=4, D_out=1 in the second WAIT cycle: Done pulses exactly one cycle later, Busy falls the cycle after, Err=0.
REQ-032 Amount=6, D_out=1 during the first GAP: only one coin (10) is emitted, then DONE; Remain is discarded.
REQ-033 Amount=0 with Start: Err pulses one cycle, Busy stays 0, D_in stays 00.
REQ-034 Amount=3, D_C=1 in WAIT then D_out=1: Change_seen=1 persists after Done until the next Start clears it.
REQ-035 Rst=0 asserted while D_in=10: D_in=00 and Busy=0 from the next edge, and Start is ignored while Rst=0.

Source files
------------

// File: rtl/cyq_coin_feeder_if.sv
// Request/coin handshake between a payment controller and the coin feeder.
// The feeder uses the slave view; the requester uses the master view.
interface cyq_coin_feeder_if;
    logic       Start;
    logic [3:0] Amount;
    logic       D_out;
    logic       D_C;
    logic [1:0] D_in;
    logic       Busy;
    logic       Done;
    logic       Err;
    logic       Change_seen;

    modport master (
        output Start, Amount, D_out, D_C,
        input  D_in, Busy, Done, Err, Change_seen
    );

    modport slave (
        input  Start, Amount, D_out, D_C,
        output D_in, Busy, Done, Err, Change_seen
    );
endinterface

// File: rtl/cyq_coin_feeder.sv
// Coin feeder: splits a half-unit amount into greedy 1.0/0.5 coin pulses
// separated by idle gaps, then waits for the machine to dispense or time out.
module cyq_coin_feeder #(
    parameter int GAP     = 1,
    parameter int TIMEOUT = 8
) (
    input logic               Clk,
    input logic               Rst,
    cyq_coin_feeder_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COIN,
        ST_GAP,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic [2:0] GAP_LAST  = 3'(GAP - 1);
    localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

    state_t     state;
    logic [3:0] remain;
    logic [2:0] gap_cnt;
    logic [3:0] wait_cnt;
    logic [1:0] d_in;
    logic       busy;
    logic       done;
    logic       err;
    logic       change_seen;

    // Greedy choice: a 1.0 coin whenever at least two half-units remain.
    function automatic logic [1:0] coin_for(input logic [3:0] r);
        return (r >= 4'd2) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [3:0] after_coin(input logic [3:0] r);
        return (r >= 4'd2) ? r - 4'd2 : r - 4'd1;
    endfunction

    // D_in is registered, so each coin is loaded on the edge that enters COIN
    // and is therefore visible for exactly the cycle spent in COIN.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state       <= ST_IDLE;
            remain      <= '0;
            gap_cnt     <= '0;
            wait_cnt    <= '0;
            d_in        <= 2'b00;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            change_seen <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update in
            // this block based on the values from before the clock edge.
            done <= 1'b0;
            err  <= 1'b0;

            if (state != ST_IDLE && bus.D_C)
                change_seen <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (bus.Start) begin
                        if (bus.Amount != 4'd0) begin
                            state       <= ST_COIN;
                            d_in        <= coin_for(bus.Amount);
                            remain      <= after_coin(bus.Amount);
                            busy        <= 1'b1;
                            change_seen <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                ST_COIN: begin
                    d_in <= 2'b00;
                    if (bus.D_out) begin
                        state  <= ST_DONE;
                        remain <= '0;
                        done   <= 1'b1;
                    end else begin
                        state   <= ST_GAP;
                        gap_cnt <= '0;
                    end
                end

                ST_GAP: begin
                    if (bus.D_out) begin
                        state  <= ST_DONE;
                        remain <= '0;
                        done   <= 1'b1;
                    end else if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        if (remain != 4'd0) begin
                            state  <= ST_COIN;
                            d_in   <= coin_for(remain);
                            remain <= after_coin(remain);
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= '0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 3'd1;
                    end
                end

                ST_WAIT: begin
                    if (bus.D_out) begin
                        state    <= ST_DONE;
                        wait_cnt <= '0;
                        done     <= 1'b1;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state    <= ST_IDLE;
                        wait_cnt <= '0;
                        busy     <= 1'b0;
                        err      <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                    d_in  <= 2'b00;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.D_in        = d_in;
    assign bus.Busy        = busy;
    assign bus.Done        = done;
    assign bus.Err         = err;
    assign bus.Change_seen = change_seen;

endmodule

// File: tb/tb_cyq_coin_feeder.sv
// Directed bench for cyq_coin_feeder: default instance (GAP=1, TIMEOUT=8)
// plus a slow instance (GAP=3, TIMEOUT=2) to exercise the counters.
module tb_cyq_coin_feeder;

    logic Clk = 1'b0;
    logic Rst;
    int   vectors     = 0;
    int   miscompares = 0;

    cyq_coin_feeder_if bus ();
    cyq_coin_feeder_if bus2 ();

    cyq_coin_feeder #(.GAP(1), .TIMEOUT(8)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    cyq_coin_feeder #(.GAP(3), .TIMEOUT(2)) dut_slow (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus2)
    );

    always #5 Clk = ~Clk;

    // Inputs change and outputs are observed 1 time unit after each rising edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        bus.Start = 1'b1;
        bus.Amount = 4'd5;
        bus2.Start = 1'b1;
        bus2.Amount = 4'd5;
        step();
        step();
        vectors++;
        if (bus.D_in !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_d_in: got %b expected 00", bus.D_in);
        end
        vectors++;
        if ({bus.Busy, bus.Done, bus.Err, bus.Change_seen} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {bus.Busy, bus.Done, bus.Err, bus.Change_seen});
        end
        vectors++;
        if ({bus2.Busy, bus2.D_in} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_slow: got %b expected 000", {bus2.Busy, bus2.D_in});
        end
        bus.Start = 1'b0;
        bus2.Start = 1'b0;
        Rst = 1'b1;
        step();
        vectors++;
        if ({bus.Busy, bus.D_in} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_release: got %b expected 000", {bus.Busy, bus.D_in});
        end
    endtask

    task automatic test_timeout();
        logic [1:0] exp_din [14] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00,
                                     2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                                     2'b00, 2'b00};
        bus.Start = 1'b1;
        bus.Amount = 4'd5;
        step();
        bus.Start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            vectors++;
            if (bus.D_in !== exp_din[i]) begin
                miscompares++;
                $display("FAIL timeout_d_in[%0d]: got %b expected %b", i, bus.D_in, exp_din[i]);
            end
            vectors++;
            if ({bus.Busy, bus.Err, bus.Done} !== 3'b100) begin
                miscompares++;
                $display("FAIL timeout_flags[%0d]: busy/err/done got %b expected 100",
                         i, {bus.Busy, bus.Err, bus.Done});
            end
            step();
        end
        vectors++;
        if ({bus.Err, bus.Busy, bus.D_in} !== 4'b1000) begin
            miscompares++;
            $display("FAIL timeout_err: err/busy/d_in got %b expected 1000",
                     {bus.Err, bus.Busy, bus.D_in});
        end
        step();
        vectors++;
        if ({bus.Err, bus.Busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL timeout_err_pulse: err/busy got %b expected 00", {bus.Err, bus.Busy});
        end
    endtask

    task automatic test_dout_in_wait();
        logic [1:0] exp_din [6] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
        bus.Start = 1'b1;
        bus.Amount = 4'd4;
        step();
        bus.Start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (bus.D_in !== exp_din[i]) begin
                miscompares++;
                $display("FAIL wait_d_in[%0d]: got %b expected %b", i, bus.D_in, exp_din[i]);
            end
            if (i == 5) bus.D_out = 1'b1;
            step();
        end
        bus.D_out = 1'b0;
        vectors++;
        if ({bus.Done, bus.Busy, bus.Err, bus.D_in} !== 5'b11000) begin
            miscompares++;
            $display("FAIL wait_done: done/busy/err/d_in got %b expected 11000",
                     {bus.Done, bus.Busy, bus.Err, bus.D_in});
        end
        step();
        vectors++;
        if ({bus.Done, bus.Busy, bus.Err} !== 3'b000) begin
            miscompares++;
            $display("FAIL wait_after_done: done/busy/err got %b expected 000",
                     {bus.Done, bus.Busy, bus.Err});
        end
    endtask

    task automatic test_dout_in_gap();
        bus.Start = 1'b1;
        bus.Amount = 4'd6;
        step();
        bus.Start = 1'b0;
        vectors++;
        if (bus.D_in !== 2'b10) begin
            miscompares++;
            $display("FAIL gap_first_coin: got %b expected 10", bus.D_in);
        end
        step();
        vectors++;
        if ({bus.Busy, bus.D_in} !== 3'b100) begin
            miscompares++;
            $display("FAIL gap_idle: busy/d_in got %b expected 100", {bus.Busy, bus.D_in});
        end
        bus.D_out = 1'b1;
        step();
        bus.D_out = 1'b0;
        vectors++;
        if ({bus.Done, bus.D_in} !== 3'b100) begin
            miscompares++;
            $display("FAIL gap_done: done/d_in got %b expected 100", {bus.Done, bus.D_in});
        end
        step();
        vectors++;
        if ({bus.Done, bus.Busy, bus.D_in} !== 4'b0000) begin
            miscompares++;
            $display("FAIL gap_idle_after: done/busy/d_in got %b expected 0000",
                     {bus.Done, bus.Busy, bus.D_in});
        end
        step();
        vectors++;
        if ({bus.Busy, bus.D_in} !== 3'b000) begin
            miscompares++;
            $display("FAIL gap_discard: busy/d_in got %b expected 000", {bus.Busy, bus.D_in});
        end
    endtask

    task automatic test_zero_amount();
        bus.Start = 1'b1;
        bus.Amount = 4'd0;
        step();
        bus.Start = 1'b0;
        vectors++;
        if ({bus.Err, bus.Busy, bus.D_in} !== 4'b1000) begin
            miscompares++;
            $display("FAIL zero_err: err/busy/d_in got %b expected 1000",
                     {bus.Err, bus.Busy, bus.D_in});
        end
        step();
        vectors++;
        if ({bus.Err, bus.Busy, bus.D_in} !== 4'b0000) begin
            miscompares++;
            $display("FAIL zero_after: err/busy/d_in got %b expected 0000",
                     {bus.Err, bus.Busy, bus.D_in});
        end
    endtask

    task automatic test_change_seen();
        bus.Start = 1'b1;
        bus.Amount = 4'd3;
        step();
        bus.Start = 1'b0;
        step();
        vectors++;
        step();
        if (bus.D_in !== 2'b01) begin
            miscompares++;
            $display("FAIL change_half_coin: got %b expected 01", bus.D_in);
        end
        step();
        step();
        vectors++;
        if ({bus.Busy, bus.D_in, bus.Change_seen} !== 4'b1000) begin
            miscompares++;
            $display("FAIL change_wait: busy/d_in/chg got %b expected 1000",
                     {bus.Busy, bus.D_in, bus.Change_seen});
        end
        bus.D_C = 1'b1;
        step();
        bus.D_C = 1'b0;
        vectors++;
        if (bus.Change_seen !== 1'b1) begin
            miscompares++;
            $display("FAIL change_set: got %b expected 1", bus.Change_seen);
        end
        bus.D_out = 1'b1;
        step();
        bus.D_out = 1'b0;
        vectors++;
        if ({bus.Done, bus.Change_seen} !== 2'b11) begin
            miscompares++;
            $display("FAIL change_done: done/chg got %b expected 11", {bus.Done, bus.Change_seen});
        end
        step();
        step();
        vectors++;
        if ({bus.Busy, bus.Change_seen} !== 2'b01) begin
            miscompares++;
            $display("FAIL change_sticky: busy/chg got %b expected 01", {bus.Busy, bus.Change_seen});
        end
        bus.Start = 1'b1;
        bus.Amount = 4'd2;
        step();
        bus.Start = 1'b0;
        vectors++;
        if ({bus.Change_seen, bus.D_in} !== 3'b010) begin
            miscompares++;
            $display("FAIL change_cleared: chg/d_in got %b expected 010", {bus.Change_seen, bus.D_in});
        end
        bus.D_out = 1'b1;
        bus.D_C = 1'b1;
        step();
        bus.D_out = 1'b0;
        bus.D_C = 1'b0;
        vectors++;
        if ({bus.Done, bus.Change_seen, bus.D_in} !== 4'b1100) begin
            miscompares++;
            $display("FAIL both_same_cycle: done/chg/d_in got %b expected 1100",
                     {bus.Done, bus.Change_seen, bus.D_in});
        end
        step();
        vectors++;
        if ({bus.Busy, bus.Change_seen} !== 2'b01) begin
            miscompares++;
            $display("FAIL both_after: busy/chg got %b expected 01", {bus.Busy, bus.Change_seen});
        end
    endtask

    task automatic test_start_ignored();
        bus.Start = 1'b1;
        bus.Amount = 4'd3;
        step();
        bus.Amount = 4'd15;
        vectors++;
        if (bus.D_in !== 2'b10) begin
            miscompares++;
            $display("FAIL ignore_first: got %b expected 10", bus.D_in);
        end
        step();
        step();
        vectors++;
        if ({bus.Busy, bus.D_in} !== 3'b101) begin
            miscompares++;
            $display("FAIL ignore_second: busy/d_in got %b expected 101", {bus.Busy, bus.D_in});
        end
        bus.Start = 1'b0;
        bus.D_out = 1'b1;
        step();
        bus.D_out = 1'b0;
        step();
        vectors++;
        if ({bus.Busy, bus.D_in} !== 3'b000) begin
            miscompares++;
            $display("FAIL ignore_end: busy/d_in got %b expected 000", {bus.Busy, bus.D_in});
        end
    endtask

    task automatic test_reset_mid();
        bus.Start = 1'b1;
        bus.Amount = 4'd7;
        step();
        bus.Start = 1'b0;
        vectors++;
        if (bus.D_in !== 2'b10) begin
            miscompares++;
            $display("FAIL mid_coin: got %b expected 10", bus.D_in);
        end
        Rst = 1'b0;
        bus.Start = 1'b1;
        bus.Amount = 4'd5;
        step();
        vectors++;
        if ({bus.Busy, bus.D_in} !== 3'b000) begin
            miscompares++;
            $display("FAIL mid_abort: busy/d_in got %b expected 000", {bus.Busy, bus.D_in});
        end
        step();
        vectors++;
        if ({bus.Busy, bus.D_in, bus.Err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL mid_start_in_reset: busy/d_in/err got %b expected 0000",
                     {bus.Busy, bus.D_in, bus.Err});
        end
        Rst = 1'b1;
        bus.Start = 1'b0;
        step();
        vectors++;
        if ({bus.Busy, bus.D_in} !== 3'b000) begin
            miscompares++;
            $display("FAIL mid_release: busy/d_in got %b expected 000", {bus.Busy, bus.D_in});
        end
    endtask

    task automatic test_slow_gap_timeout();
        logic [1:0] exp_din [10] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b01,
                                     2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        bus2.Start = 1'b1;
        bus2.Amount = 4'd3;
        step();
        bus2.Start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if ({bus2.Busy, bus2.Err, bus2.D_in} !== {2'b10, exp_din[i]}) begin
                miscompares++;
                $display("FAIL slow_seq[%0d]: busy/err/d_in got %b expected %b",
                         i, {bus2.Busy, bus2.Err, bus2.D_in}, {2'b10, exp_din[i]});
            end
            step();
        end
        vectors++;
        if ({bus2.Busy, bus2.Err, bus2.D_in} !== 4'b0100) begin
            miscompares++;
            $display("FAIL slow_timeout: busy/err/d_in got %b expected 0100",
                     {bus2.Busy, bus2.Err, bus2.D_in});
        end
        step();
    endtask

    initial begin
        Rst = 1'b0;
        bus.Start = 1'b0;
        bus.Amount = 4'd0;
        bus.D_out = 1'b0;
        bus.D_C = 1'b0;
        bus2.Start = 1'b0;
        bus2.Amount = 4'd0;
        bus2.D_out = 1'b0;
        bus2.D_C = 1'b0;

        test_reset();
        test_timeout();
        step();
        test_dout_in_wait();
        step();
        test_dout_in_gap();
        test_zero_amount();
        test_change_seen();
        step();
        test_start_ignored();
        step();
        test_reset_mid();
        test_slow_gap_timeout();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
